// File: rtl/fetch_queue.sv
// Instruction fetch stage: PC register plus a 2-entry {instr, pc+4} queue feeding decode.
// Define FETCH_STATS_EN to add saturating stall/flush counters (stall_cnt, flush_cnt).
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] inst_addr,
    input  logic [31:0] inst_data,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc4
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt
`endif
);

    localparam int DEPTH = 2;

    logic [31:0] pc_reg, pc_next;
    logic [1:0]  count_reg, count_next;
    logic        rd_ptr_reg, rd_ptr_next;
    logic        wr_ptr_reg, wr_ptr_next;

    logic [31:0] instr_mem [DEPTH];
    logic [31:0] pc4_mem   [DEPTH];
    logic [DEPTH-1:0] wr_en;

    logic [31:0] pc_plus4;
    logic        pop;
    logic        push;

    assign inst_addr = pc_reg;
    assign pc_plus4  = pc_reg + 32'd4;

    // Branch kills the head combinationally so decode never consumes a wrong-path entry.
    always_comb begin
        if_valid = (count_reg != 2'd0) && !branch_taken;
        pop      = if_valid && id_ready;
        push     = ((count_reg < 2'd2) || pop) && !branch_taken;
        if_instr = if_valid ? instr_mem[rd_ptr_reg] : 32'h0;
        if_pc4   = if_valid ? pc4_mem[rd_ptr_reg]   : 32'h0;
    end

    always_comb begin
        pc_next     = pc_reg;
        count_next  = count_reg;
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        if (branch_taken) begin
            pc_next     = {branch_target[31:2], 2'b00};
            count_next  = 2'd0;
            rd_ptr_next = 1'b0;
            wr_ptr_next = 1'b0;
        end else begin
            if (push) begin
                pc_next     = pc_plus4;
                wr_ptr_next = ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_next = ~rd_ptr_reg;
            end
            case ({push, pop})
                2'b10:   count_next = count_reg + 2'd1;
                2'b01:   count_next = count_reg - 2'd1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg     <= RESET_PC;
            count_reg  <= 2'd0;
            rd_ptr_reg <= 1'b0;
            wr_ptr_reg <= 1'b0;
        end else begin
            pc_reg     <= pc_next;
            count_reg  <= count_next;
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
        end
    end

    // Storage needs no reset: count gates visibility of every entry.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            assign wr_en[gi] = push && !reset && (wr_ptr_reg == 1'(gi));

            always_ff @(posedge clk) begin
                if (wr_en[gi]) begin
                    instr_mem[gi] <= inst_data;
                    pc4_mem[gi]   <= pc_plus4;
                end
            end
        end
    endgenerate

`ifdef FETCH_STATS_EN
    logic [15:0] stall_cnt_reg, stall_cnt_next;
    logic [15:0] flush_cnt_reg, flush_cnt_next;

    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        flush_cnt_next = flush_cnt_reg;
        if (if_valid && !id_ready && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_next = stall_cnt_reg + 16'd1;
        end
        if (branch_taken && (flush_cnt_reg != 16'hFFFF)) begin
            flush_cnt_next = flush_cnt_reg + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_reg <= 16'd0;
            flush_cnt_reg <= 16'd0;
        end else begin
            stall_cnt_reg <= stall_cnt_next;
            flush_cnt_reg <= flush_cnt_next;
        end
    end

    assign stall_cnt = stall_cnt_reg;
    assign flush_cnt = flush_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: cycle-exact vector table for the corner cases, then a
// randomized stream checked against an in-order scoreboard of expected fetches.
module tb_fetch_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inst_addr;
    logic [31:0] inst_data;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc4;
`ifdef FETCH_STATS_EN
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;
`endif

    always #5 clk = ~clk;

    fetch_queue #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .inst_addr    (inst_addr),
        .inst_data    (inst_data),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .id_ready     (id_ready),
        .if_valid     (if_valid),
        .if_instr     (if_instr),
        .if_pc4       (if_pc4)
`ifdef FETCH_STATS_EN
        ,
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
`endif
    );

    function automatic logic [31:0] ram_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
    endfunction

    assign inst_data = ram_word(inst_addr);

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst;
        logic        br;
        logic [31:0] tgt;
        logic        rdy;
        logic        ev;
        logic [31:0] ea;
        logic [31:0] ep4;
        logic [15:0] es;
        logic [15:0] ef;
    } vec_t;

    typedef struct {
        logic [31:0] pc4;
        logic [31:0] instr;
    } sb_t;

    vec_t        vq[$];
    sb_t         exp_q[$];
    logic [31:0] next_fetch;
    int          pops;

    task automatic add_vec(input logic rst, input logic br, input logic [31:0] tgt,
                           input logic rdy, input logic ev, input logic [31:0] ea,
                           input logic [31:0] ep4, input logic [15:0] es, input logic [15:0] ef);
        vec_t v;
        v.rst = rst; v.br = br; v.tgt = tgt; v.rdy = rdy;
        v.ev = ev; v.ea = ea; v.ep4 = ep4; v.es = es; v.ef = ef;
        vq.push_back(v);
    endtask

    task automatic refill();
        sb_t e;
        while (exp_q.size() < 4) begin
            e.pc4   = next_fetch + 32'd4;
            e.instr = ram_word(next_fetch);
            exp_q.push_back(e);
            next_fetch = next_fetch + 32'd4;
        end
    endtask

    initial begin
        vec_t v;
        sb_t  e;
        logic [31:0] exp_instr;

        //      rst   br    tgt            rdy   ev    addr           pc4            stall  flush
        add_vec(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0000, 32'h0,         16'd0, 16'd0);
        add_vec(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0004, 32'h0000_0004, 16'd0, 16'd0);
        add_vec(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0008, 32'h0000_0004, 16'd1, 16'd0);
        add_vec(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0008, 32'h0000_0004, 16'd2, 16'd0);
        add_vec(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_0008, 32'h0000_0004, 16'd3, 16'd0);
        add_vec(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0008, 32'h0000_0004, 16'd4, 16'd0);
        add_vec(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_000C, 32'h0000_0008, 16'd4, 16'd0);
        add_vec(1'b0, 1'b1, 32'h0000_0043, 1'b1, 1'b0, 32'h0000_000C, 32'h0,         16'd5, 16'd0);
        add_vec(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0000_0040, 32'h0,         16'd5, 16'd1);
        add_vec(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0044, 32'h0000_0044, 16'd5, 16'd1);
        add_vec(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0048, 32'h0000_0048, 16'd5, 16'd1);
        add_vec(1'b0, 1'b0, 32'h0,         1'b0, 1'b1, 32'h0000_004C, 32'h0000_004C, 16'd5, 16'd1);
        add_vec(1'b1, 1'b1, 32'h0000_0100, 1'b1, 1'b0, 32'h0000_0050, 32'h0,         16'd6, 16'd1);
        add_vec(1'b0, 1'b0, 32'h0,         1'b0, 1'b0, 32'h0000_0000, 32'h0,         16'd0, 16'd0);
        add_vec(1'b0, 1'b1, 32'hFFFF_FFFB, 1'b1, 1'b0, 32'h0000_0004, 32'h0,         16'd0, 16'd0);
        add_vec(1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 32'hFFFF_FFF8, 32'h0,         16'd0, 16'd1);
        add_vec(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 16'd0, 16'd1);
        add_vec(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0000, 32'h0000_0000, 16'd0, 16'd1);
        add_vec(1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0000_0004, 32'h0000_0004, 16'd0, 16'd1);

        reset         = 1'b1;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        id_ready      = 1'b0;
        repeat (3) @(posedge clk);

        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i];
            #1;
            reset         = v.rst;
            branch_taken  = v.br;
            branch_target = v.tgt;
            id_ready      = v.rdy;
            @(negedge clk);
            exp_instr = v.ev ? ram_word(v.ep4 - 32'd4) : 32'h0;
            $display("row %0d: valid=%0b addr=%h pc4=%h instr=%h", i, if_valid, inst_addr, if_pc4, if_instr);
            check($sformatf("row%0d_valid", i), {31'd0, if_valid}, {31'd0, v.ev});
            check($sformatf("row%0d_addr", i), inst_addr, v.ea);
            check($sformatf("row%0d_pc4", i), if_pc4, v.ev ? v.ep4 : 32'h0);
            check($sformatf("row%0d_instr", i), if_instr, exp_instr);
`ifdef FETCH_STATS_EN
            check($sformatf("row%0d_stall", i), {16'd0, stall_cnt}, {16'd0, v.es});
            check($sformatf("row%0d_flush", i), {16'd0, flush_cnt}, {16'd0, v.ef});
`endif
            @(posedge clk);
        end

        // Random stream: every pop must match the next address in program order.
        pops = 0;
        next_fetch = 32'h0;
        for (int c = 0; c < 400; c++) begin
            #1;
            reset         = (c == 0) || ($urandom_range(0, 63) == 0);
            branch_taken  = ($urandom_range(0, 15) == 0);
            branch_target = $urandom;
            id_ready      = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (reset) begin
                exp_q.delete();
                next_fetch = 32'h0;
                refill();
            end else if (branch_taken) begin
                check("stream_branch_valid", {31'd0, if_valid}, 32'd0);
                exp_q.delete();
                next_fetch = {branch_target[31:2], 2'b00};
                refill();
            end else if (if_valid && id_ready) begin
                e = exp_q.pop_front();
                $display("pop %0d: pc4=%h instr=%h", pops, if_pc4, if_instr);
                check("stream_pc4", if_pc4, e.pc4);
                check("stream_instr", if_instr, e.instr);
                pops++;
                refill();
            end
            @(posedge clk);
        end
        check("stream_pops", (pops >= 100) ? 32'd1 : 32'd0, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
